fact_job_scheduler: RTL and testbench
=====================================

// Module: fact_job_scheduler
// PURPOSE
//  Shares one factorial engine (datapath + FSM pair) between NREQ requesters.
//  Round-robin arbitration picks the next requester and sequences the engine
//  through a start/done handshake. The scheduler routes the 32-bit result
//  back to the winning requester.
//  Trivial inputs (0, 1) and overflow inputs are resolved locally, without
//  starting the engine. A watchdog aborts a hung engine.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  NW       8    width of each requested operand
//  TIMEOUT  255  max cycles in WAIT before abort (>=2, fits in 16 bits)
//  MAX_N    12   largest operand whose factorial fits in 32 bits
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  req_valid    in   NREQ     requester i has a job pending
//  req_num      in   NREQ*NW  operand of requester i, slice [i*NW +: NW]
//  req_ready    out  NREQ     one-hot grant, accept strobe
//  rsp_valid    out  NREQ     one-hot, one-cycle response pulse
//  rsp_result   out  32       result, valid with any rsp_valid bit
//  rsp_error    out  1        1 = overflow or timeout, rsp_result = 0
//  eng_start    out  1        one-cycle pulse, engine loads eng_num
//  eng_num      out  NW       operand to engine, held stable through WAIT
//  eng_done     in   1        engine finished, eng_result valid this cycle
//  eng_result   in   32       engine result
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  Reset (sync, dominant over every other event, any state):
//   - state=IDLE, rr_ptr=0, wdog=0
//   - all outputs 0
//   - a job in flight is dropped: no rsp_valid, no eng_start
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; bypass path IDLE -> RESP.
//  IDLE:
//   - grant g = first set req_valid bit at or after rr_ptr, wrapping NREQ-1 -> 0
//   - req_ready = onehot(g), combinational, asserted only in IDLE
//   - accept: at the edge with any req_valid, latch g and num = req_num[g]
//   - same edge: rr_ptr <= (g+1) mod NREQ
//   - no req_valid -> stay in IDLE, req_ready = 0
//  Classify the latched num:
//   - num <= 1 -> RESP, result = 1, error = 0
//   - num > MAX_N -> RESP, result = 0, error = 1
//   - otherwise -> ISSUE
//  ISSUE (one cycle): eng_start = 1, eng_num = num; next state WAIT, wdog = 0.
//  WAIT:
//   - wdog increments every cycle
//   - eng_done -> capture eng_result, error = 0, go RESP
//   - wdog == TIMEOUT without eng_done -> result 0, error = 1, go RESP
//   - eng_done in the same cycle as the timeout -> done wins
//   - eng_done outside WAIT is ignored
//  RESP (one cycle):
//   - rsp_valid = onehot(g), with rsp_result and rsp_error; then IDLE
//   - no backpressure: requesters must sample the pulse
//   - req_ready is 0 here, so a new job is granted one cycle after RESP
//  Latency:
//   - bypass: accept edge + 1 cycle to rsp_valid
//   - engine job: accept, ISSUE, WAIT (k cycles), RESP
//  Requester i dropping req_valid before its grant: no side effect.
//  eng_num, rsp_result and rsp_error are registered; all are 0 outside their
//  valid cycles.
// STRUCTURE
//  Package fact_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} sched_state_t
//   - localparam FACT_MAX_N = 12
//   - localparam FACT_W = 32
//  Sub-module rr_arbiter #(NREQ):
//   - inputs: req, ptr
//   - outputs: onehot grant, binary index, any
//   - purely combinational
//  Top of this block: state register, job registers, watchdog counter.
// TESTING
//  Reset:
//   - rst=1 for 2 cycles mid-WAIT
//   -> busy=0, outputs 0, no rsp_valid; the next job is granted normally
//  Single job, engine model (done 6 cycles after start):
//   - req 0, num=5
//   -> one eng_start with eng_num=5; rsp_valid=4'b0001, rsp_result=120, rsp_error=0
//  Fairness:
//   - all 4 req_valid held high, each num=3
//   -> grant order 1,2,3 then 0,1 after a first grant of 0; every rsp_result=6
//  Bypass and overflow:
//   - num=0 -> rsp_result=1, no eng_start
//   - num=13 -> rsp_error=1, rsp_result=0, no eng_start
//   - both: rsp_valid 1 cycle after accept
//  Timeout: TIMEOUT=20, engine never asserts done
//   -> rsp_error=1 exactly 20 WAIT cycles after ISSUE
//   -> a later eng_done is ignored
//  Boundary: num=12
//   -> rsp_result=479001600
//   -> a done-at-timeout collision yields error=0

Source files
------------

// File: rtl/fact_pkg.sv
// fact_pkg: shared types and constants for the factorial job scheduler
package fact_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} sched_state_t;
  localparam int FACT_MAX_N = 12;
  localparam int FACT_W = 32;
endpackage

// File: rtl/fact_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) begin
        idx = PW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
  end
  assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/fact_job_scheduler.sv
// fact_job_scheduler: round-robin sharing of one factorial engine with local bypass and watchdog
module fact_job_scheduler
  import fact_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NW = 8,
  parameter int TIMEOUT = 255,
  parameter int MAX_N = FACT_MAX_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*NW-1:0]  req_num,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [FACT_W-1:0]   rsp_result,
  output logic                rsp_error,
  output logic                eng_start,
  output logic [NW-1:0]       eng_num,
  input  logic                eng_done,
  input  logic [FACT_W-1:0]   eng_result,
  output logic                busy
);
  localparam int PW = $clog2(NREQ);
  sched_state_t state;
  logic [PW-1:0] rr_ptr, gidx, g;
  logic [NREQ-1:0] gnt;
  logic any;
  logic [NW-1:0] num_sel;
  logic [15:0] wdog, wdog_nxt;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(gnt),
    .idx(gidx),
    .any(any)
  );
  assign num_sel = req_num[int'(gidx)*NW +: NW];
  assign req_ready = (state == S_IDLE && !rst) ? gnt : '0;
  assign busy = state != S_IDLE;
  assign wdog_nxt = wdog + 16'd1;
  // Response fields are loaded on the edge entering RESP and cleared on the way out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      g <= '0;
      wdog <= '0;
      eng_start <= 1'b0;
      eng_num <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_error <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_error <= 1'b0;
      case (state)
        S_IDLE:
          if (any) begin
            g <= gidx;
            rr_ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
            if (num_sel <= NW'(1)) begin
              state <= S_RESP;
              rsp_valid <= gnt;
              rsp_result <= FACT_W'(1);
            end else if (num_sel > NW'(MAX_N)) begin
              state <= S_RESP;
              rsp_valid <= gnt;
              rsp_error <= 1'b1;
            end else begin
              state <= S_ISSUE;
              eng_start <= 1'b1;
              eng_num <= num_sel;
            end
          end
        S_ISSUE: begin
          state <= S_WAIT;
          wdog <= '0;
        end
        S_WAIT: begin
          wdog <= wdog_nxt;
          // done is tested first so a completion on the timeout cycle still succeeds
          if (eng_done) begin
            state <= S_RESP;
            rsp_valid <= NREQ'(1) << g;
            rsp_result <= eng_result;
            eng_num <= '0;
          end else if (wdog_nxt == 16'(TIMEOUT)) begin
            state <= S_RESP;
            rsp_valid <= NREQ'(1) << g;
            rsp_error <= 1'b1;
            eng_num <= '0;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fact_job_scheduler.sv
// tb_fact_job_scheduler: directed self-checking bench with a behavioural factorial engine
module tb_fact_job_scheduler;
  localparam int NREQ = 4, NW = 8, TO = 20;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*NW-1:0] req_num = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [31:0] rsp_result, eng_result;
  logic rsp_error, eng_start, eng_done, busy;
  logic [NW-1:0] eng_num;
  logic force_done = 0;
  int eng_delay = 0, cnt = 0;
  logic [NW-1:0] eng_op = '0;
  int checks = 0, fails = 0;

  fact_job_scheduler #(.NREQ(NREQ), .NW(NW), .TIMEOUT(TO), .MAX_N(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .eng_start(eng_start), .eng_num(eng_num), .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input logic [NW-1:0] n);
    logic [31:0] p = 1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  // engine: done pulses in the eng_delay-th cycle after start; eng_delay 0 means never
  always @(posedge clk)
    if (eng_start) begin
      cnt <= eng_delay;
      eng_op <= eng_num;
    end else if (cnt > 0) cnt <= cnt - 1;
  assign eng_done = (cnt == 1) | force_done;
  assign eng_result = fact(eng_op);

  task automatic run_job(input int id, input logic [NW-1:0] num, output logic [NREQ-1:0] v,
                         output logic [31:0] r, output logic e, output int lat,
                         output int starts, output logic [NW-1:0] en);
    int n;
    @(negedge clk);
    req_valid = NREQ'(1) << id;
    req_num[id*NW +: NW] = num;
    n = 0;
    while (!req_ready[id] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    starts = 0;
    en = '0;
    while (rsp_valid == '0 && lat < 100) begin
      if (eng_start) begin
        starts++;
        en = eng_num;
      end
      @(negedge clk);
      lat++;
    end
    v = rsp_valid;
    r = rsp_result;
    e = rsp_error;
  endtask

  task automatic test_reset();
    rst = 1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_result !== '0) begin fails++; $display("FAIL reset_result: got %0d want 0", rsp_result); end
    checks++; if (rsp_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", rsp_error); end
    checks++; if (eng_start !== 1'b0) begin fails++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
    checks++; if (eng_num !== '0) begin fails++; $display("FAIL reset_eng_num: got %0d want 0", eng_num); end
    req_valid = '0;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int n;
    eng_delay = 3;
    req_num = {8'd3, 8'd3, 8'd3, 8'd3};
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (rsp_valid == '0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++; if (rsp_valid !== exp_g[i]) begin fails++; $display("FAIL fair_grant%0d: got %b want %b", i, rsp_valid, exp_g[i]); end
      checks++; if (rsp_result !== 32'd6) begin fails++; $display("FAIL fair_result%0d: got %0d want 6", i, rsp_result); end
      if (i == 5) req_valid = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] v; logic [31:0] r; logic e; int lat, st; logic [NW-1:0] en;
    eng_delay = 6;
    run_job(0, 8'd5, v, r, e, lat, st, en);
    checks++; if (st !== 1) begin fails++; $display("FAIL single_starts: got %0d want 1", st); end
    checks++; if (en !== 8'd5) begin fails++; $display("FAIL single_eng_num: got %0d want 5", en); end
    checks++; if (v !== 4'b0001) begin fails++; $display("FAIL single_valid: got %b want 0001", v); end
    checks++; if (r !== 32'd120) begin fails++; $display("FAIL single_result: got %0d want 120", r); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL single_error: got %b want 0", e); end
    checks++; if (lat !== 8) begin fails++; $display("FAIL single_latency: got %0d want 8", lat); end
    @(negedge clk);
    checks++; if (rsp_valid !== '0) begin fails++; $display("FAIL single_pulse: got %b want 0000", rsp_valid); end
    checks++; if (rsp_result !== '0) begin fails++; $display("FAIL single_result_clear: got %0d want 0", rsp_result); end
  endtask

  task automatic test_bypass();
    logic [NREQ-1:0] v; logic [31:0] r; logic e; int lat, st; logic [NW-1:0] en;
    eng_delay = 6;
    run_job(3, 8'd0, v, r, e, lat, st, en);
    checks++; if (v !== 4'b1000) begin fails++; $display("FAIL zero_valid: got %b want 1000", v); end
    checks++; if (r !== 32'd1) begin fails++; $display("FAIL zero_result: got %0d want 1", r); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL zero_error: got %b want 0", e); end
    checks++; if (st !== 0) begin fails++; $display("FAIL zero_starts: got %0d want 0", st); end
    checks++; if (lat !== 1) begin fails++; $display("FAIL zero_latency: got %0d want 1", lat); end
    run_job(1, 8'd13, v, r, e, lat, st, en);
    checks++; if (v !== 4'b0010) begin fails++; $display("FAIL ovf_valid: got %b want 0010", v); end
    checks++; if (r !== 32'd0) begin fails++; $display("FAIL ovf_result: got %0d want 0", r); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL ovf_error: got %b want 1", e); end
    checks++; if (st !== 0) begin fails++; $display("FAIL ovf_starts: got %0d want 0", st); end
    checks++; if (lat !== 1) begin fails++; $display("FAIL ovf_latency: got %0d want 1", lat); end
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] v; logic [31:0] r; logic e; int lat, st, seen; logic [NW-1:0] en;
    eng_delay = 0;
    run_job(2, 8'd5, v, r, e, lat, st, en);
    checks++; if (v !== 4'b0100) begin fails++; $display("FAIL to_valid: got %b want 0100", v); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL to_error: got %b want 1", e); end
    checks++; if (r !== 32'd0) begin fails++; $display("FAIL to_result: got %0d want 0", r); end
    checks++; if (lat - 2 !== TO) begin fails++; $display("FAIL to_wait_cycles: got %0d want %0d", lat - 2, TO); end
    @(negedge clk);
    force_done = 1;
    @(negedge clk);
    force_done = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL to_late_done: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_boundary();
    logic [NREQ-1:0] v; logic [31:0] r; logic e; int lat, st; logic [NW-1:0] en;
    eng_delay = TO;
    run_job(1, 8'd12, v, r, e, lat, st, en);
    checks++; if (v !== 4'b0010) begin fails++; $display("FAIL max_valid: got %b want 0010", v); end
    checks++; if (r !== 32'd479001600) begin fails++; $display("FAIL max_result: got %0d want 479001600", r); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL max_collision_error: got %b want 0", e); end
    checks++; if (lat !== TO + 2) begin fails++; $display("FAIL max_latency: got %0d want %0d", lat, TO + 2); end
  endtask

  task automatic test_mid_wait_reset();
    logic [NREQ-1:0] v; logic [31:0] r; logic e; int lat, st, n, seen; logic [NW-1:0] en;
    eng_delay = 0;
    @(negedge clk);
    req_valid = 4'b0100;
    req_num[2*NW +: NW] = 8'd7;
    n = 0;
    while (!eng_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (eng_num !== '0) begin fails++; $display("FAIL mid_eng_num: got %0d want 0", eng_num); end
    rst = 0;
    seen = 0;
    repeat (TO + 10) begin
      @(negedge clk);
      if (rsp_valid != '0 || eng_start) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL mid_dropped: got %0d active cycles want 0", seen); end
    eng_delay = 3;
    run_job(2, 8'd4, v, r, e, lat, st, en);
    checks++; if (v !== 4'b0100) begin fails++; $display("FAIL mid_next_valid: got %b want 0100", v); end
    checks++; if (r !== 32'd24) begin fails++; $display("FAIL mid_next_result: got %0d want 24", r); end
    checks++; if (lat !== 5) begin fails++; $display("FAIL mid_next_latency: got %0d want 5", lat); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_bypass();
    test_timeout();
    test_boundary();
    test_mid_wait_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
